dm_port_arbiter: RTL and testbench

- Shares the single port of the data-memory BRAM (dm_ram, 4096x32, byte write enables, 1-cycle synchronous read) between two requesters: the pipeline EX-stage access path (port C, priority) and a DMA/debug loader (port D).
- Sits between the Access stage and dm_ram. Owns grant, stall, read-return routing and anti-starvation.
- Requesters present pre-aligned data and byte enables. The arbiter never shifts data.

---
 rtl/dm_arb_pkg.sv | 18 +
 rtl/dm_port_arbiter_if.sv | 48 ++++
 rtl/dm_arb_starve_ctr.sv | 50 +++++
 rtl/dm_port_arbiter.sv | 127 ++++++++++++
 tb/tb_dm_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter: grant owner, arbitration
// state and the DM word-address width.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_C,
        ARB_D
    } arb_owner_t;

    typedef enum logic {
        NORMAL,
        FORCE_D
    } arb_state_t;

    localparam int DM_WORD_BITS = 12;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the pipeline (C), DMA (D) and dm_ram signals around the arbiter.
// slave  : the arbiter's view.
// master : the view of the requesters and the RAM.
interface dm_port_arbiter_if;

    logic        c_req;
    logic        c_we;
    logic [3:0]  c_be;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_stall;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport slave (
        input  c_req, c_we, c_be, c_addr, c_wdata,
        output c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output c_req, c_we, c_be, c_addr, c_wdata,
        input  c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );

endinterface

// File: rtl/dm_arb_starve_ctr.sv
// Anti-starvation for port D: counts consecutive cycles in which D asked
// for DM but C took the RAM. After STARVE_MAX such denials in a row the
// next cycle runs in FORCE_D, where D has priority for one cycle only.
module dm_arb_starve_ctr
    import dm_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_de,
    input  logic       i_c_won,
    output arb_state_t o_state
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_denied;

    assign w_denied = i_de && i_c_won;

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= NORMAL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Any cycle that is not a denial breaks the streak; FORCE_D lasts one cycle.
    always_comb begin
        w_state_nxt = NORMAL;
        w_cnt_nxt   = '0;
        if (w_denied) begin
            if (r_cnt == 3'(STARVE_MAX - 1)) begin
                w_state_nxt = FORCE_D;
            end else begin
                w_cnt_nxt = r_cnt + 3'd1;
            end
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port dm_ram arbiter: pipeline port C has priority, DMA port D is
// forced through after a run of denials. Read data comes back one cycle
// after the grant and is steered by the registered read owner.
// Optional macro ARB_PERF_CNT_EN adds saturating conflict / forced-grant
// performance counters.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int          STARVE_MAX = 4,
    parameter logic [15:0] DM_LIMIT   = 16'h3000
) (
    input  logic               clk,
    input  logic               rstn,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]        perf_conflicts,
    output logic [15:0]        perf_forced,
`endif
    dm_port_arbiter_if.slave   bus
);

    arb_state_t  w_state;
    arb_owner_t  w_winner;
    arb_owner_t  r_rd_owner;
    logic        w_ce;
    logic        w_de;
    logic        w_win_we;
    logic [3:0]  w_win_be;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic        w_unused;

    // Only the low 16 address bits decode DM; the word index is addr[13:2].
    assign w_unused = ^{bus.c_addr[31:16], bus.c_addr[1:0],
                        bus.d_addr[31:16], bus.d_addr[1:0]};

    assign w_ce = bus.c_req && (bus.c_addr[15:0] < DM_LIMIT);
    assign w_de = bus.d_req && (bus.d_addr[15:0] < DM_LIMIT);

    dm_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rstn    (rstn),
        .i_de    (w_de),
        .i_c_won (w_winner == ARB_C),
        .o_state (w_state)
    );

    // Winner selection: C first normally, D first for the single FORCE_D cycle.
    always_comb begin
        w_winner = ARB_NONE;
        if (w_state == NORMAL) begin
            if (w_ce)      w_winner = ARB_C;
            else if (w_de) w_winner = ARB_D;
        end else begin
            if (w_de)      w_winner = ARB_D;
            else if (w_ce) w_winner = ARB_C;
        end
    end

    // RAM-side mux from the winner; everything zero when nobody wins.
    always_comb begin
        w_win_we    = 1'b0;
        w_win_be    = '0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        case (w_winner)
            ARB_C: begin
                w_win_we    = bus.c_we;
                w_win_be    = bus.c_be;
                w_win_addr  = bus.c_addr;
                w_win_wdata = bus.c_wdata;
            end
            ARB_D: begin
                w_win_we    = bus.d_we;
                w_win_be    = bus.d_be;
                w_win_addr  = bus.d_addr;
                w_win_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    assign bus.ram_en   = (w_winner != ARB_NONE);
    assign bus.ram_we   = w_win_we ? w_win_be : 4'b0;
    assign bus.ram_addr = w_win_addr[DM_WORD_BITS+1:2];
    assign bus.ram_din  = w_win_wdata;

    assign bus.c_stall  = w_ce && (w_winner != ARB_C);
    assign bus.d_gnt    = (w_winner == ARB_D);

    // Remember who issued this cycle's read so the BRAM output is tagged next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_owner <= ARB_NONE;
        end else begin
            r_rd_owner <= (w_winner != ARB_NONE && !w_win_we) ? w_winner : ARB_NONE;
        end
    end

    assign bus.c_rvalid = (r_rd_owner == ARB_C);
    assign bus.d_rvalid = (r_rd_owner == ARB_D);
    assign bus.c_rdata  = bus.ram_dout;
    assign bus.d_rdata  = bus.ram_dout;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_conflicts;
    logic [15:0] r_perf_forced;

    // Saturating counters: both-requesting cycles and forced D grants.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_conflicts <= '0;
            r_perf_forced    <= '0;
        end else begin
            if (w_ce && w_de && (r_perf_conflicts != '1))
                r_perf_conflicts <= r_perf_conflicts + 32'd1;
            if ((w_state == FORCE_D) && (w_winner == ARB_D) && (r_perf_forced != '1))
                r_perf_forced <= r_perf_forced + 16'd1;
        end
    end

    assign perf_conflicts = r_perf_conflicts;
    assign perf_forced    = r_perf_forced;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed vector table, multi-cycle
// starvation / reset sequences, and a randomized run against a request-level
// reference model with a shadow memory.
module tb_dm_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dm_port_arbiter_if bus_if();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflicts;
    logic [15:0] perf_forced;
`endif

    dm_port_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .DM_LIMIT   (16'h3000)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
`ifdef ARB_PERF_CNT_EN
        .perf_conflicts (perf_conflicts),
        .perf_forced    (perf_forced),
`endif
        .bus            (bus_if)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Behavioural dm_ram: read-first, byte writes, reloaded while in reset.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
        end else if (bus_if.ram_en) begin
            bus_if.ram_dout <= mem[bus_if.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus_if.ram_we[b]) mem[bus_if.ram_addr][8*b +: 8] <= bus_if.ram_din[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_c(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus_if.c_req = req; bus_if.c_we = we; bus_if.c_be = be;
        bus_if.c_addr = addr; bus_if.c_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus_if.d_req = req; bus_if.d_we = we; bus_if.d_be = be;
        bus_if.d_addr = addr; bus_if.d_wdata = wd;
    endtask

    task automatic idle();
        set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        rstn = 1'b0;
        idle();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic conflict();
        set_c(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        set_d(1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    endtask

    typedef struct {
        logic        c_req, c_we;
        logic [3:0]  c_be;
        logic [31:0] c_addr, c_wdata;
        logic        d_req, d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr, d_wdata;
        logic        e_stall, e_gnt, e_en;
        logic [3:0]  e_we;
        logic [11:0] e_addr;
        logic [31:0] e_din;
        logic        e_crv, e_drv;
    } vec_t;

    vec_t vt[9];

    // Reference model state.
    logic [31:0] shadow [0:4095];
    int          m_owner;
    logic [31:0] m_rdata;
    int          m_streak;
    bit          m_force;
    int          m_conf;
    int          m_forced;

    initial begin
        idle();
        bus_if.ram_dout = 32'h0;

        vt[0] = '{1'b0,1'b0,4'h0,32'h0,32'h0,
                  1'b1,1'b0,4'hF,32'h0000_0100,32'h1111_1111,
                  1'b0,1'b1,1'b1,4'h0,12'h040,32'h1111_1111,1'b0,1'b1};
        vt[1] = '{1'b1,1'b1,4'h3,32'h0000_0204,32'hCAFE_BEEF,
                  1'b1,1'b0,4'hF,32'h0000_0100,32'h2222_2222,
                  1'b0,1'b0,1'b1,4'h3,12'h081,32'hCAFE_BEEF,1'b0,1'b0};
        vt[2] = '{1'b1,1'b0,4'hF,32'h0000_3000,32'h3333_3333,
                  1'b1,1'b0,4'hF,32'h0000_0000,32'h4444_4444,
                  1'b0,1'b1,1'b1,4'h0,12'h000,32'h4444_4444,1'b0,1'b1};
        vt[3] = '{1'b1,1'b0,4'hF,32'h0000_3000,32'h5555_5555,
                  1'b0,1'b0,4'h0,32'h0,32'h0,
                  1'b0,1'b0,1'b0,4'h0,12'h000,32'h0,1'b0,1'b0};
        vt[4] = '{1'b0,1'b1,4'hF,32'h0000_0010,32'h6666_6666,
                  1'b0,1'b1,4'hF,32'h0000_0020,32'h7777_7777,
                  1'b0,1'b0,1'b0,4'h0,12'h000,32'h0,1'b0,1'b0};
        vt[5] = '{1'b1,1'b0,4'hF,32'hABCD_0008,32'h8888_8888,
                  1'b0,1'b0,4'h0,32'h0,32'h0,
                  1'b0,1'b0,1'b1,4'h0,12'h002,32'h8888_8888,1'b1,1'b0};
        vt[6] = '{1'b0,1'b0,4'h0,32'h0,32'h0,
                  1'b1,1'b1,4'hF,32'h0000_0FFC,32'h9999_9999,
                  1'b0,1'b1,1'b1,4'hF,12'h3FF,32'h9999_9999,1'b0,1'b0};
        vt[7] = '{1'b1,1'b0,4'hF,32'h0000_3004,32'hAAAA_AAAA,
                  1'b1,1'b0,4'h1,32'h4000_2FFC,32'hBBBB_BBBB,
                  1'b0,1'b1,1'b1,4'h0,12'hBFF,32'hBBBB_BBBB,1'b0,1'b1};
        vt[8] = '{1'b1,1'b1,4'hC,32'h0000_2000,32'hDDDD_0000,
                  1'b1,1'b1,4'hF,32'h0000_0004,32'h0000_EEEE,
                  1'b0,1'b0,1'b1,4'hC,12'h800,32'hDDDD_0000,1'b0,1'b0};

        // Reset state.
        do_reset();
        #1;
        chk("rst_c_rvalid", {31'b0, bus_if.c_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'b0, bus_if.d_rvalid}, 32'd0);
        chk("rst_ram_en",   {31'b0, bus_if.ram_en},   32'd0);

        // Directed single-request vectors, each from a fresh reset.
        foreach (vt[i]) begin
            do_reset();
            set_c(vt[i].c_req, vt[i].c_we, vt[i].c_be, vt[i].c_addr, vt[i].c_wdata);
            set_d(vt[i].d_req, vt[i].d_we, vt[i].d_be, vt[i].d_addr, vt[i].d_wdata);
            #1;
            chk($sformatf("v%0d_c_stall", i),  {31'b0, bus_if.c_stall}, {31'b0, vt[i].e_stall});
            chk($sformatf("v%0d_d_gnt", i),    {31'b0, bus_if.d_gnt},   {31'b0, vt[i].e_gnt});
            chk($sformatf("v%0d_ram_en", i),   {31'b0, bus_if.ram_en},  {31'b0, vt[i].e_en});
            chk($sformatf("v%0d_ram_we", i),   {28'b0, bus_if.ram_we},  {28'b0, vt[i].e_we});
            chk($sformatf("v%0d_ram_addr", i), {20'b0, bus_if.ram_addr}, {20'b0, vt[i].e_addr});
            chk($sformatf("v%0d_ram_din", i),  bus_if.ram_din,          vt[i].e_din);
            @(negedge clk);
            idle();
            #1;
            chk($sformatf("v%0d_c_rvalid", i), {31'b0, bus_if.c_rvalid}, {31'b0, vt[i].e_crv});
            chk($sformatf("v%0d_d_rvalid", i), {31'b0, bus_if.d_rvalid}, {31'b0, vt[i].e_drv});
        end

        // Continuous conflict: D forced through every 5th cycle.
        do_reset();
        conflict();
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("starve%0d_d_gnt", k),   {31'b0, bus_if.d_gnt},   {31'b0, (k % 5) == 4});
            chk($sformatf("starve%0d_c_stall", k), {31'b0, bus_if.c_stall}, {31'b0, (k % 5) == 4});
            if (k > 0) begin
                chk($sformatf("starve%0d_c_rvalid", k), {31'b0, bus_if.c_rvalid}, {31'b0, ((k-1) % 5) != 4});
                chk($sformatf("starve%0d_d_rvalid", k), {31'b0, bus_if.d_rvalid}, {31'b0, ((k-1) % 5) == 4});
            end
            @(negedge clk);
        end

        // Reset lands between a C read grant and its return; starvation history is lost.
        do_reset();
        conflict();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("pre_rst%0d_d_gnt", k), {31'b0, bus_if.d_gnt}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("mid_rst_c_stall", {31'b0, bus_if.c_stall}, 32'd0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_c_rvalid", {31'b0, bus_if.c_rvalid}, 32'd0);
        chk("mid_rst_d_rvalid", {31'b0, bus_if.d_rvalid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("post_rst%0d_d_gnt", k), {31'b0, bus_if.d_gnt}, {31'b0, k == 4});
            @(negedge clk);
        end
        // C drops its request: the waiting D goes through at once.
        set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("c_drop_d_gnt", {31'b0, bus_if.d_gnt}, 32'd1);
        @(negedge clk);

`ifdef ARB_PERF_CNT_EN
        do_reset();
        conflict();
        repeat (10) @(negedge clk);
        idle();
        #1;
        chk("perf_conflicts", perf_conflicts, 32'd10);
        chk("perf_forced",    {16'b0, perf_forced}, 32'd2);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
        m_owner = 0; m_rdata = '0; m_streak = 0; m_force = 1'b0; m_conf = 0; m_forced = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ca, da, win_din, win_addr;
            logic [3:0]  win_be;
            logic        ce, de, win_we;
            int          win;
            ca = {16'($urandom), ($urandom_range(0, 5) == 0) ? 16'h3000 + 16'($urandom_range(0, 16'hCFFF))
                                                             : {10'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}};
            da = {16'($urandom), ($urandom_range(0, 5) == 0) ? 16'h3000 + 16'($urandom_range(0, 16'hCFFF))
                                                             : {10'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}};
            set_c($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), ca, $urandom);
            set_d($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), da, $urandom);
            #1;
            ce = bus_if.c_req && (int'(ca[15:0]) < 'h3000);
            de = bus_if.d_req && (int'(da[15:0]) < 'h3000);
            if (m_force) win = de ? 2 : (ce ? 1 : 0);
            else         win = ce ? 1 : (de ? 2 : 0);
            win_we = 1'b0; win_be = 4'h0; win_addr = 32'h0; win_din = 32'h0;
            if (win == 1) begin win_we = bus_if.c_we; win_be = bus_if.c_be; win_addr = ca; win_din = bus_if.c_wdata; end
            if (win == 2) begin win_we = bus_if.d_we; win_be = bus_if.d_be; win_addr = da; win_din = bus_if.d_wdata; end

            chk("rnd_c_stall",  {31'b0, bus_if.c_stall}, {31'b0, ce && win != 1});
            chk("rnd_d_gnt",    {31'b0, bus_if.d_gnt},   {31'b0, win == 2});
            chk("rnd_ram_en",   {31'b0, bus_if.ram_en},  {31'b0, win != 0});
            chk("rnd_ram_we",   {28'b0, bus_if.ram_we},  {28'b0, win_we ? win_be : 4'h0});
            chk("rnd_ram_addr", {20'b0, bus_if.ram_addr}, {20'b0, win_addr[13:2]});
            chk("rnd_ram_din",  bus_if.ram_din, win_din);
            chk("rnd_c_rvalid", {31'b0, bus_if.c_rvalid}, {31'b0, m_owner == 1});
            chk("rnd_d_rvalid", {31'b0, bus_if.d_rvalid}, {31'b0, m_owner == 2});
            if (m_owner == 1) chk("rnd_c_rdata", bus_if.c_rdata, m_rdata);
            if (m_owner == 2) chk("rnd_d_rdata", bus_if.d_rdata, m_rdata);

            if (ce && de) m_conf++;
            if (m_force && win == 2) m_forced++;
            m_owner = 0;
            if (win != 0) begin
                if (win_we) begin
                    for (int b = 0; b < 4; b++)
                        if (win_be[b]) shadow[win_addr[13:2]][8*b +: 8] = win_din[8*b +: 8];
                end else begin
                    m_owner = win;
                    m_rdata = shadow[win_addr[13:2]];
                end
            end
            m_force = 1'b0;
            if (de && win == 1) begin
                m_streak++;
                if (m_streak == STARVE_MAX) begin
                    m_force  = 1'b1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            @(negedge clk);
        end
`ifdef ARB_PERF_CNT_EN
        idle();
        #1;
        chk("rnd_perf_conflicts", perf_conflicts, 32'(m_conf));
        chk("rnd_perf_forced",    {16'b0, perf_forced}, 32'(m_forced));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
